// File: rtl/key_event_reader.sv
// key_event_reader
// Debounces the keypad scanner's KeyRead/BCDKey pair and queues exactly one
// code per physical press into a small first-word-fall-through FIFO. The
// calculator core drains the FIFO with a KeyValid/KeyPop handshake.
module key_event_reader #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            KeyRead,
  input  logic [3:0]                      BCDKey,
  input  logic                            KeyPop,
  output logic                            KeyValid,
  output logic [3:0]                      KeyCode,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FifoCount,
  output logic                            Overflow
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   DEB     = 16'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Debounce state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [3:0]  r_cur;
  logic [3:0]  w_cur_nxt;
  logic        w_push;

  // FIFO state
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;

  // Debounce FSM state, stability counter and latched code registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_cur   <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_cur_nxt;
    end
  end

  // Debounce next-state logic; a push is requested only on press confirmation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (KeyRead) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = 16'd1;
          w_cur_nxt   = BCDKey;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!KeyRead) begin
          w_state_nxt = IDLE;
        end else if (BCDKey != r_cur) begin
          // A different code restarts the stability window on the new code
          w_cnt_nxt = 16'd1;
          w_cur_nxt = BCDKey;
        end else if (r_cnt == DEB) begin
          w_state_nxt = HELD;
          w_push      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      HELD: begin
        // Code changes while held are ignored: no auto-repeat, no re-push
        if (!KeyRead) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = 16'd1;
        end else begin
          w_state_nxt = HELD;
        end
      end
      RELEASE_WAIT: begin
        if (KeyRead) begin
          // Release bounce: key is still considered held
          w_state_nxt = HELD;
        end else if (r_cnt == DEB) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
        w_cur_nxt   = 4'h0;
      end
    endcase
  end

  // FIFO handshake decode: pop only when non-empty, write when room or popping
  always_comb begin
    w_pop  = 1'b0;
    w_full = 1'b0;
    w_wr   = 1'b0;
    w_pop  = KeyPop && (r_count != {CW{1'b0}});
    w_full = (r_count == DEPTH_C);
    if (w_push && (!w_full || w_pop)) begin
      w_wr = 1'b1;
    end else begin
      w_wr = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rptr     <= {PW{1'b0}};
      r_wptr     <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CW'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; entries are only read after being written, so no reset
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wptr] <= r_cur;
    end
  end

  // Outputs come straight from registers; head reads zero when empty
  assign KeyValid  = (r_count != {CW{1'b0}});
  assign KeyCode   = KeyValid ? r_mem[r_rptr] : 4'h0;
  assign FifoCount = r_count;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_reader.sv
// Self-checking bench for key_event_reader: directed scenarios plus random
// key/pop traffic compared against a run-length based reference model.
module tb_key_event_reader;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          KeyRead;
  logic [3:0]    BCDKey;
  logic          KeyPop;
  logic          KeyValid;
  logic [3:0]    KeyCode;
  logic [CW-1:0] FifoCount;
  logic          Overflow;
  logic [CW+5:0] obs;

  int errors = 0;
  int checks = 0;

  // Reference model: confirmed-down flag, run length of qualifying samples,
  // candidate code, FIFO contents as a queue, sticky overflow.
  bit         m_down;
  int         m_run;
  logic [3:0] m_code;
  logic [3:0] m_q[$];
  bit         m_ovf;

  key_event_reader #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .KeyRead(KeyRead), .BCDKey(BCDKey),
    .KeyPop(KeyPop), .KeyValid(KeyValid), .KeyCode(KeyCode),
    .FifoCount(FifoCount), .Overflow(Overflow)
  );

  assign obs = {KeyValid, KeyCode, FifoCount, Overflow};

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_down = 1'b0;
    m_run  = 0;
    m_code = 4'h0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  // A press is confirmed after D+1 consecutive samples of the same code;
  // a release after D+1 consecutive low samples.
  task automatic model_step(input logic kr, input logic [3:0] code, input logic pop);
    bit push;
    bit pop_ok;
    bit full_before;
    push = 1'b0;
    if (!m_down) begin
      if (kr) begin
        if (m_run > 0 && code == m_code) m_run++;
        else begin
          m_run  = 1;
          m_code = code;
        end
        if (m_run == D + 1) begin
          push   = 1'b1;
          m_down = 1'b1;
          m_run  = 0;
        end
      end else m_run = 0;
    end else begin
      if (!kr) begin
        m_run++;
        if (m_run == D + 1) begin
          m_down = 1'b0;
          m_run  = 0;
        end
      end else m_run = 0;
    end
    full_before = (m_q.size() == DEPTH);
    pop_ok      = pop && (m_q.size() > 0);
    if (pop_ok) void'(m_q.pop_front());
    if (push) begin
      if (full_before && !pop_ok) m_ovf = 1'b1;
      else m_q.push_back(m_code);
    end
  endtask

  function automatic logic [CW+5:0] model_outs();
    logic [3:0] hc;
    hc = (m_q.size() > 0) ? m_q[0] : 4'h0;
    return {m_q.size() > 0, hc, CW'(m_q.size()), m_ovf};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle past it
  task automatic tick(input logic kr, input logic [3:0] code, input logic pop);
    KeyRead = kr;
    BCDKey  = code;
    KeyPop  = pop;
    @(posedge CLK);
    model_step(kr, code, pop);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    for (int i = 0; i < D + 1; i++) tick(1'b1, code, 1'b0);
  endtask

  task automatic release_key();
    for (int i = 0; i < D + 2; i++) tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    KeyRead = 1'b0;
    KeyPop  = 1'b0;
    BCDKey  = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    KeyRead = 1'b1;
    BCDKey  = 4'h5;
    KeyPop  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    do_reset();
    checks++;
    if (obs !== model_outs()) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", obs, model_outs());
    end
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 4'h7, 1'b0);
      checks++;
      if (KeyValid !== (i >= D + 1)) begin
        errors++;
        $display("FAIL clean_valid edge %0d: got %b want %b", i, KeyValid, (i >= D + 1));
      end
    end
    checks++;
    if (KeyCode !== 4'h7 || FifoCount !== CW'(1)) begin
      errors++;
      $display("FAIL clean_code: got code %h count %0d want 7/1", KeyCode, FifoCount);
    end
    release_key();
    tick(1'b0, 4'h0, 1'b1);
    checks++;
    if (KeyValid !== 1'b0 || KeyCode !== 4'h0) begin
      errors++;
      $display("FAIL clean_drain: got valid %b code %h want 0/0", KeyValid, KeyCode);
    end
  endtask

  task automatic test_press_bounce();
    logic [7:0] pat;
    pat = 8'b1111_1011;  // applied LSB first: 1,1,0,1,1,1,1,1
    for (int i = 0; i < 8; i++) begin
      tick(pat[i], 4'h3, 1'b0);
      checks++;
      if (KeyValid !== (i == 7)) begin
        errors++;
        $display("FAIL bounce_valid step %0d: got %b want %b", i, KeyValid, (i == 7));
      end
    end
    checks++;
    if (KeyCode !== 4'h3 || obs !== model_outs()) begin
      errors++;
      $display("FAIL bounce_code: got %h want %h", obs, model_outs());
    end
    release_key();
    tick(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_code_change();
    for (int i = 0; i < D + 5; i++) begin
      tick(1'b1, (i < 2) ? 4'h2 : 4'h9, 1'b0);
      checks++;
      if (KeyValid === 1'b1 && KeyCode === 4'h2) begin
        errors++;
        $display("FAIL change_stale: got code %h want not 2", KeyCode);
      end
    end
    checks++;
    if (FifoCount !== CW'(1) || KeyCode !== 4'h9) begin
      errors++;
      $display("FAIL change_push: got count %0d code %h want 1/9", FifoCount, KeyCode);
    end
    release_key();
    tick(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_release_bounce();
    press(4'h5);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 4'h5, 1'b0);
    checks++;
    if (FifoCount !== CW'(1)) begin
      errors++;
      $display("FAIL relbounce_single: got count %0d want 1", FifoCount);
    end
    release_key();
    press(4'hA);
    checks++;
    if (FifoCount !== CW'(2) || KeyCode !== 4'h5) begin
      errors++;
      $display("FAIL relbounce_two: got count %0d head %h want 2/5", FifoCount, KeyCode);
    end
    tick(1'b1, 4'hA, 1'b1);
    checks++;
    if (KeyCode !== 4'hA || obs !== model_outs()) begin
      errors++;
      $display("FAIL relbounce_tail: got %h want %h", obs, model_outs());
    end
    release_key();
    tick(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      press(4'(k));
      release_key();
    end
    checks++;
    if (FifoCount !== CW'(4) || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got count %0d ovf %b want 4/1", FifoCount, Overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (KeyCode !== 4'(k)) begin
        errors++;
        $display("FAIL ovf_order %0d: got %h want %h", k, KeyCode, 4'(k));
      end
      tick(1'b0, 4'h0, 1'b1);
    end
    checks++;
    if (KeyValid !== 1'b0 || KeyCode !== 4'h0 || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_empty: got %h want %h", obs, model_outs());
    end
    tick(1'b0, 4'h0, 1'b1);
    checks++;
    if (obs !== model_outs()) begin
      errors++;
      $display("FAIL ovf_pop_empty: got %h want %h", obs, model_outs());
    end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_head [3];
    exp_head[0] = 4'h3;
    exp_head[1] = 4'h4;
    exp_head[2] = 4'h6;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      press(4'(k));
      release_key();
    end
    for (int i = 0; i < D; i++) tick(1'b1, 4'h6, 1'b0);
    tick(1'b1, 4'h6, 1'b1);
    checks++;
    if (FifoCount !== CW'(4) || Overflow !== 1'b0 || KeyCode !== 4'h2) begin
      errors++;
      $display("FAIL fullpp: got count %0d ovf %b head %h want 4/0/2", FifoCount, Overflow, KeyCode);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'h6, 1'b1);
      checks++;
      if (KeyCode !== exp_head[i]) begin
        errors++;
        $display("FAIL fullpp_tail %0d: got %h want %h", i, KeyCode, exp_head[i]);
      end
    end
    // Asynchronous reset while the key is still held
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    for (int i = 1; i <= D + 1; i++) begin
      tick(1'b1, 4'h6, 1'b0);
      checks++;
      if (KeyValid !== (i == D + 1)) begin
        errors++;
        $display("FAIL repush edge %0d: got %b want %b", i, KeyValid, (i == D + 1));
      end
    end
    checks++;
    if (KeyCode !== 4'h6 || obs !== model_outs()) begin
      errors++;
      $display("FAIL repush_code: got %h want %h", obs, model_outs());
    end
  endtask

  task automatic test_random();
    logic       kr;
    logic [3:0] code;
    int         run;
    kr   = 1'b0;
    code = 4'h0;
    run  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        kr  = 1'($urandom_range(0, 1));
        run = int'($urandom_range(1, 2 * D + 3));
      end
      run--;
      if ($urandom_range(0, 9) == 0) code = 4'($urandom_range(0, 15));
      tick(kr, code, ($urandom_range(0, 3) == 0));
      checks++;
      if (obs !== model_outs()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs, model_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_code_change();
    test_release_bounce();
    test_overflow();
    test_full_push_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
